// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator for the instruction-fetch stage
//
// Produces the fetch address with a valid/ready handshake to instruction
// memory. Handles pipeline stall, jump and trap redirects (trap wins) and
// buffers a redirect that arrives while a fetch request is still unaccepted.
//
// Optional feature macro: PC_ALIGN_CHK_EN
//   defined   : redirect targets with nonzero low log2(INST_BYTES) bits are
//               stored with those bits cleared and misalign_o pulses for one
//               cycle after the redirect is accepted or buffered.
//   undefined : redirect addresses used verbatim, misalign_o tied 0.
//
// Parameters
//   ADDR_W      width of PC and redirect addresses
//   RESET_VEC   PC value after reset
//   INST_BYTES  sequential increment (power of two, >= 1)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-high
//   stall_i        hold PC, suppress new fetch requests (ignored in WAIT)
//   jump_flag_i    jump/branch redirect request (1-cycle)
//   jump_addr_i    jump target
//   trap_flag_i    trap redirect request (1-cycle), beats jump
//   trap_addr_i    trap vector
//   fetch_ready_i  imem accepts pc_o this cycle
//   fetch_valid_o  pc_o is a valid fetch request
//   pc_o           current fetch address
//   ce_o           imem chip enable, low only in BOOT
//   pend_o         a redirect is buffered awaiting the handshake
//   misalign_o     redirect target was misaligned (one-cycle pulse)

module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              fetch_ready_i,
    output logic              fetch_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              pend_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [ADDR_W-1:0] buf_addr_d;
    logic              buf_valid_q;
    logic              buf_valid_d;
    logic              buf_trap_q;
    logic              buf_trap_d;
    logic              misalign_q;
    logic              misalign_d;

    logic              fire;
    logic              redir;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_addr;
    logic              redir_misalign;
    logic              redir_taken;

    assign fire      = fetch_valid_o && fetch_ready_i;
    assign redir     = trap_flag_i | jump_flag_i;
    assign redir_raw = trap_flag_i ? trap_addr_i : jump_addr_i;

`ifdef PC_ALIGN_CHK_EN
    // Low-order bits that must be zero in an aligned address; all-zero mask
    // when INST_BYTES is 1, which makes the check vacuous.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

    assign redir_addr     = redir_raw & ~ALIGN_MASK;
    assign redir_misalign = |(redir_raw & ALIGN_MASK);
`else
    assign redir_addr     = redir_raw;
    assign redir_misalign = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: if (fetch_valid_o && !fetch_ready_i) state_d = S_WAIT;
            S_WAIT:  if (fetch_ready_i) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Once a request is raised in WAIT it must stay up with a stable address,
    // so stall_i only gates new requests from FETCH.
    always_comb begin
        fetch_valid_o = 1'b0;
        ce_o          = 1'b1;
        case (state_q)
            S_BOOT: begin
                fetch_valid_o = 1'b0;
                ce_o          = 1'b0;
            end
            S_FETCH: fetch_valid_o = !stall_i;
            S_WAIT:  fetch_valid_o = 1'b1;
            default: begin
                fetch_valid_o = 1'b0;
                ce_o          = 1'b0;
            end
        endcase
    end

    // ---------------- next-PC and redirect buffer ----------------
    always_comb begin
        pc_d        = pc_q;
        buf_addr_d  = buf_addr_q;
        buf_valid_d = buf_valid_q;
        buf_trap_d  = buf_trap_q;
        redir_taken = 1'b0;

        if (buf_valid_q && fire) begin
            // Buffered redirect drains on the handshake; a fresh redirect in
            // the same cycle is newer and wins.
            buf_valid_d = 1'b0;
            buf_trap_d  = 1'b0;
            if (redir) begin
                pc_d        = redir_addr;
                redir_taken = 1'b1;
            end else begin
                pc_d = buf_addr_q;
            end
        end else if (redir && (fire || !fetch_valid_o)) begin
            // No outstanding request to protect: redirect immediately.
            pc_d        = redir_addr;
            redir_taken = 1'b1;
        end else if (redir) begin
            // Request outstanding and not accepted: pc_o must stay stable, so
            // park the target. A pending trap is never displaced by a jump.
            if (!buf_valid_q || trap_flag_i || !buf_trap_q) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = redir_addr;
                buf_trap_d  = trap_flag_i;
                redir_taken = 1'b1;
            end
        end else if (fire) begin
            pc_d = pc_q + ADDR_W'(INST_BYTES);
        end

        misalign_d = redir_taken && redir_misalign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VEC;
            buf_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            buf_trap_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            buf_addr_q  <= buf_addr_d;
            buf_valid_q <= buf_valid_d;
            buf_trap_q  <= buf_trap_d;
            misalign_q  <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pend_o     = buf_valid_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        trap_flag;
    logic [31:0] trap_addr;
    logic        ready;
    logic        valid;
    logic [31:0] pc;
    logic        ce;
    logic        pend;
    logic        misalign;

    // 16-bit instance: free-running, always ready, used for the wrap check
    logic        w_zero = 1'b0;
    logic        w_ready = 1'b1;
    logic [15:0] w_addr = 16'h0000;
    logic        w_valid;
    logic [15:0] w_pc;
    logic        w_ce;
    logic        w_pend;
    logic        w_misalign;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef PC_ALIGN_CHK_EN
    localparam logic [31:0] EXP_MIS_PC = 32'h0000_0100;
    localparam logic [31:0] EXP_MIS    = 32'd1;
`else
    localparam logic [31:0] EXP_MIS_PC = 32'h0000_0102;
    localparam logic [31:0] EXP_MIS    = 32'd0;
`endif

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0000_0000), .INST_BYTES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .trap_flag_i   (trap_flag),
        .trap_addr_i   (trap_addr),
        .fetch_ready_i (ready),
        .fetch_valid_o (valid),
        .pc_o          (pc),
        .ce_o          (ce),
        .pend_o        (pend),
        .misalign_o    (misalign)
    );

    pc_gen #(.ADDR_W(16), .RESET_VEC(16'hFFF4), .INST_BYTES(4)) dut16 (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (w_zero),
        .jump_flag_i   (w_zero),
        .jump_addr_i   (w_addr),
        .trap_flag_i   (w_zero),
        .trap_addr_i   (w_addr),
        .fetch_ready_i (w_ready),
        .fetch_valid_o (w_valid),
        .pc_o          (w_pc),
        .ce_o          (w_ce),
        .pend_o        (w_pend),
        .misalign_o    (w_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        jump_flag = 1'b0;
        jump_addr = '0;
        trap_flag = 1'b0;
        trap_addr = '0;
        ready     = 1'b1;

        // reset state
        tick();
        chk("rst_pc",    pc, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ce",    32'(ce), 32'd0);
        chk("rst_pend",  32'(pend), 32'd0);
        chk("rst_mis",   32'(misalign), 32'd0);
        chk("w_rst_pc",  32'(w_pc), 32'h0000_FFF4);
        rst = 1'b0;

        // BOOT -> FETCH, then sequential fetches
        tick();
        chk("boot_pc",    pc, 32'h0);
        chk("boot_valid", 32'(valid), 32'd1);
        chk("boot_ce",    32'(ce), 32'd1);
        chk("w_boot_pc",  32'(w_pc), 32'h0000_FFF4);
        tick();
        chk("seq_pc4",  pc, 32'h4);
        chk("w_pc_ff8", 32'(w_pc), 32'h0000_FFF8);
        tick();
        chk("seq_pc8",  pc, 32'h8);
        chk("w_pc_ffc", 32'(w_pc), 32'h0000_FFFC);

        // not ready at 0x8, then stalled while waiting
        ready = 1'b0;
        #1;
        chk("wait_valid0", 32'(valid), 32'd1);
        tick();
        chk("w_wrap", 32'(w_pc), 32'h0000_0000);
        stall = 1'b1;
        #1;
        chk("wait_valid1", 32'(valid), 32'd1);
        chk("wait_pc1",    pc, 32'h8);
        tick();
        chk("wait_valid2", 32'(valid), 32'd1);
        chk("wait_pc2",    pc, 32'h8);
        tick();
        chk("wait_valid3", 32'(valid), 32'd1);
        chk("wait_pc3",    pc, 32'h8);
        ready = 1'b1;
        tick();
        chk("wait_done_pc", pc, 32'hC);
        chk("stall_fetch_valid", 32'(valid), 32'd0);
        stall = 1'b0;
        tick();
        chk("seq_pc10", pc, 32'h10);

        // jump while request unaccepted -> buffered
        ready     = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h100;
        tick();
        jump_flag = 1'b0;
        chk("buf_pend",  32'(pend), 32'd1);
        chk("buf_pc",    pc, 32'h10);
        chk("buf_valid", 32'(valid), 32'd1);
        tick();
        chk("buf_pc_hold", pc, 32'h10);
        ready = 1'b1;
        tick();
        chk("buf_drain_pc",   pc, 32'h100);
        chk("buf_drain_pend", 32'(pend), 32'd0);

        // jump and trap together: trap wins
        jump_flag = 1'b1;
        jump_addr = 32'h200;
        trap_flag = 1'b1;
        trap_addr = 32'h80;
        tick();
        jump_flag = 1'b0;
        chk("both_pc", pc, 32'h80);

        // pending trap survives later jump
        ready = 1'b0;
        tick();
        trap_flag = 1'b0;
        chk("ptrap_pend", 32'(pend), 32'd1);
        jump_flag = 1'b1;
        jump_addr = 32'h300;
        tick();
        jump_flag = 1'b0;
        ready     = 1'b1;
        tick();
        chk("ptrap_pc",   pc, 32'h80);
        chk("ptrap_pend0", 32'(pend), 32'd0);

        // pending jump replaced by later jump
        ready     = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h400;
        tick();
        jump_addr = 32'h500;
        tick();
        jump_flag = 1'b0;
        ready     = 1'b1;
        tick();
        chk("jover_pc", pc, 32'h500);

        // pending jump replaced by trap
        ready     = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h600;
        tick();
        jump_flag = 1'b0;
        trap_flag = 1'b1;
        trap_addr = 32'h700;
        tick();
        trap_flag = 1'b0;
        ready     = 1'b1;
        tick();
        chk("tover_pc", pc, 32'h700);

        // redirect while stalled in FETCH applies without fetching old PC
        stall     = 1'b1;
        jump_flag = 1'b1;
        jump_addr = 32'h900;
        #1;
        chk("stall_redir_valid", 32'(valid), 32'd0);
        tick();
        stall     = 1'b0;
        jump_flag = 1'b0;
        chk("stall_redir_pc", pc, 32'h900);

        // misaligned jump target
        jump_flag = 1'b1;
        jump_addr = 32'h102;
        tick();
        jump_flag = 1'b0;
        chk("mis_pc",    pc, EXP_MIS_PC);
        chk("mis_pulse", 32'(misalign), EXP_MIS);
        tick();
        chk("mis_next_pc", pc, EXP_MIS_PC + 32'h4);
        chk("mis_clear",   32'(misalign), 32'd0);

        // reset while waiting with a buffered redirect
        ready     = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h800;
        tick();
        jump_flag = 1'b0;
        chk("rw_pend", 32'(pend), 32'd1);
        rst = 1'b1;
        tick();
        chk("rw_pc",    pc, 32'h0);
        chk("rw_valid", 32'(valid), 32'd0);
        chk("rw_pend0", 32'(pend), 32'd0);
        chk("rw_ce",    32'(ce), 32'd0);
        rst = 1'b0;

        // redirect during BOOT
        ready     = 1'b1;
        jump_flag = 1'b1;
        jump_addr = 32'hA00;
        tick();
        jump_flag = 1'b0;
        chk("bootj_pc",    pc, 32'hA00);
        chk("bootj_valid", 32'(valid), 32'd1);
        tick();
        chk("bootj_next", pc, 32'hA04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
